// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART transmitter. Bytes are issued one at a time
// with a single-cycle trigger, gated by the transmitter's idle handshake.
module uart_tx_feeder #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_wr_en,
    input  logic [7:0]                 i_wr_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow,
    input  logic                       i_tx_idle,
    output logic                       o_tx_trig,
    output logic [7:0]                 o_tx_data,
    output logic                       o_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT_BUSY, S_WAIT_IDLE} state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_acc;
    logic             pop;

    assign o_full  = (o_count == CNT_W'(DEPTH));
    assign o_empty = (o_count == '0);
    assign wr_acc  = i_wr_en && !o_full;
    assign pop     = (state == S_IDLE) && !o_empty && i_tx_idle;
    assign o_busy  = !o_empty || (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rstn && wr_acc) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !pop) begin
                o_count <= o_count + 1'b1;
            end else if (pop && !wr_acc) begin
                o_count <= o_count - 1'b1;
            end
            if (i_wr_en && o_full) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // S_TRIG ignores i_tx_idle: the transmitter still reports idle during the trigger cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            o_tx_trig <= 1'b0;
            o_tx_data <= 8'h00;
        end else begin
            o_tx_trig <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_tx_data <= mem[rd_ptr];
                        o_tx_trig <= 1'b1;
                        state     <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!i_tx_idle) begin
                        state <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (i_tx_idle) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based feeder model plus a transmitter model
// that drops idle one cycle after a trigger and stays busy for 12 cycles.
module tb_uart_tx_feeder;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full, empty, ovf, trig, busy;
    logic [CW-1:0] count;
    logic [7:0]    tx_data;
    logic          tx_idle_m = 1'b1;
    logic          stall = 1'b0;
    logic          tx_idle;

    assign tx_idle = tx_idle_m && !stall;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(ovf),
        .i_tx_idle(tx_idle), .o_tx_trig(trig), .o_tx_data(tx_data), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transmitter model: idle falls one cycle after the trigger, returns after 12 cycles.
    int tx_cnt = 0;
    bit tx_pend = 1'b0;
    always @(negedge clk) begin
        if (trig) begin
            tx_pend = 1'b1;
        end else if (tx_pend) begin
            tx_pend   = 1'b0;
            tx_idle_m = 1'b0;
            tx_cnt    = 12;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_idle_m = 1'b1;
        end
    end

    // Behavioural model: byte queue plus the issue rule (issue only when free
    // to issue and idle; after an issue, wait for idle to be seen low, then high).
    logic [7:0] q[$];
    int  cyc = 0;
    bit  started = 1'b0;
    bit  m_ovf = 1'b0, m_trig = 1'b0, m_acc, m_pop;
    bit  m_ready = 1'b1, m_skip = 1'b0, m_need_low = 1'b0, m_need_high = 1'b0;
    logic [7:0] m_data = 8'h00;
    int  last_wr_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        if (!rstn) begin
            q.delete();
            m_ovf = 1'b0; m_trig = 1'b0; m_data = 8'h00;
            m_ready = 1'b1; m_skip = 1'b0; m_need_low = 1'b0; m_need_high = 1'b0;
        end else begin
            m_acc = wr_en && (q.size() < DEPTH);
            if (wr_en && !m_acc) m_ovf = 1'b1;
            m_pop  = m_ready && (q.size() > 0) && tx_idle;
            m_trig = m_pop;
            if (m_pop) begin
                m_data  = q.pop_front();
                m_ready = 1'b0;
                m_skip  = 1'b1;
            end else if (m_skip) begin
                m_skip     = 1'b0;
                m_need_low = 1'b1;
            end else if (m_need_low) begin
                if (!tx_idle) begin
                    m_need_low  = 1'b0;
                    m_need_high = 1'b1;
                end
            end else if (m_need_high && tx_idle) begin
                m_need_high = 1'b0;
                m_ready     = 1'b1;
            end
            if (m_acc) begin
                q.push_back(wr_data);
                last_wr_cyc = cyc;
            end
        end
    end

    // Per-cycle compare against the model; also logs every DUT trigger.
    logic [7:0] dut_log[$];
    int         dut_time[$];
    always @(negedge clk) begin
        if (started) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("overflow", 32'(ovf), 32'(m_ovf));
            chk("tx_trig", 32'(trig), 32'(m_trig));
            chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("busy", 32'(busy), 32'((q.size() > 0) || !m_ready));
            if (trig) begin
                dut_log.push_back(tx_data);
                dut_time.push_back(cyc);
            end
        end
    end

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_trigs(input int n, input int limit);
        int t = 0;
        while (dut_log.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("trigger_count", 32'(dut_log.size()), 32'(n));
    endtask

    task automatic wait_quiet(input int limit);
        int t = 0;
        while (!(tx_idle_m && !busy && tx_cnt == 0) && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("quiet_reached", 32'(t < limit), 32'd1);
    endtask

    initial begin
        int base;
        int t;

        // Reset values
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(ovf), 32'd0);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_data", 32'(tx_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single byte
        base = dut_log.size();
        write_byte(8'hA5);
        wait_trigs(base + 1, 20);
        chk("single_data", 32'(dut_log[base]), 32'hA5);
        chk("single_latency", 32'(dut_time[base] - last_wr_cyc), 32'd1);
        wait_quiet(40);
        chk("single_busy_done", 32'(busy), 32'd0);
        chk("single_count_done", 32'(count), 32'd0);

        // Burst of 16 while stalled, then released
        stall = 1'b1;
        for (int i = 1; i <= 16; i++) write_byte(8'(i));
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_count", 32'(count), 32'd16);
        chk("burst_no_ovf", 32'(ovf), 32'd0);
        base = dut_log.size();
        stall = 1'b0;
        wait_trigs(base + 16, 16 * 20 + 40);
        for (int k = 0; k < 16; k++) begin
            chk("burst_order", 32'(dut_log[base+k]), 32'(k + 1));
            if (k > 0) chk("burst_gap_ge13", 32'((dut_time[base+k] - dut_time[base+k-1]) >= 13), 32'd1);
        end
        wait_quiet(40);

        // Overflow: 17 writes into a stalled transmitter
        stall = 1'b1;
        for (int i = 0; i < 17; i++) write_byte(8'(8'h40 + i));
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_model_q", 32'(q.size()), 32'd16);
        repeat (5) @(negedge clk);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        base = dut_log.size();
        stall = 1'b0;
        wait_trigs(base + 16, 16 * 20 + 40);
        for (int k = 0; k < 16; k++) chk("ovf_order", 32'(dut_log[base+k]), 32'(8'h40 + k));
        wait_quiet(40);
        repeat (20) @(negedge clk);
        chk("ovf_17th_absent", 32'(dut_log.size()), 32'(base + 16));
        chk("ovf_sticky_end", 32'(ovf), 32'd1);

        // Concurrent write and pop, then streaming across pointer wrap
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rst2_ovf_clear", 32'(ovf), 32'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) write_byte(8'(8'h80 + i));
        chk("conc_pre_count", 32'(count), 32'd3);
        base = dut_log.size();
        stall   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h83;
        @(negedge clk);
        wr_en = 1'b0;
        chk("conc_count", 32'(count), 32'd3);
        chk("conc_trig", 32'(trig), 32'd1);
        chk("conc_data", 32'(tx_data), 32'h80);
        for (int k = 4; k < 40; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            t = 0;
            while (!trig && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("stream_trig_seen", 32'(t < 100), 32'd1);
            wr_en   = 1'b1;
            wr_data = 8'(8'h80 + k);
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_trigs(base + 40, 40 * 20 + 50);
        for (int k = 0; k < 40; k++) chk("stream_order", 32'(dut_log[base+k]), 32'(8'h80 + k));
        wait_quiet(40);
        chk("stream_count_done", 32'(count), 32'd0);

        // Reset mid-frame with 5 bytes queued
        for (int i = 0; i < 6; i++) write_byte(8'(8'hB0 + i));
        t = 0;
        while (tx_idle && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("midrst_tx_busy", 32'(tx_idle), 32'd0);
        chk("midrst_pre_count", 32'(count), 32'd5);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(tx_data), 32'h00);
        base = dut_log.size();
        write_byte(8'hC3);
        t = 0;
        while (!tx_idle_m && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("midrst_no_early_trig", 32'(dut_log.size()), 32'(base));
        wait_trigs(base + 1, 20);
        chk("midrst_new_data", 32'(dut_log[base]), 32'hC3);
        wait_quiet(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and trigger sequencer directly upstream of the UART transmitter. It accepts bytes from any producer (debug logger, command responder) into a synchronous FIFO. It then issues them to the transmitter one at a time, using the transmitter's single-cycle trigger and idle-status handshake. Producers can burst bytes without tracking the serial line.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `i_wr_en`  in  1  write strobe; one byte per cycle.
- `i_wr_data`  in  8  byte to enqueue.
- `o_full`  out  1  FIFO holds `DEPTH` bytes.
- `o_empty`  out  1  FIFO holds 0 bytes.
- `o_count`  out  $clog2(DEPTH+1)  current occupancy.
- `o_overflow`  out  1  sticky; set when a write is attempted while full.
- `i_tx_idle`  in  1  transmitter idle status (high = ready for a new byte).
- `o_tx_trig`  out  1  single-cycle start pulse to the transmitter.
- `o_tx_data`  out  8  byte presented to the transmitter.
- `o_busy`  out  1  high while the FIFO is non-empty or the FSM is not in `S_IDLE`.

## Operation
- **FIFO storage:** register array of `DEPTH` x 8.
- **Pointers:** `$clog2(DEPTH)`-bit read and write pointers; they wrap naturally from `DEPTH-1` to 0.
- **Occupancy:** `o_count` is a separate counter. `o_full` and `o_empty` are decoded from `o_count`.
- **Write:**
  - A write is accepted when `i_wr_en` is high and `o_full` is low.
  - A write while full is dropped: no data is stored and no pointer moves, and `o_overflow` is set.
- **Pop:** performed only by the FSM.
  - Simultaneous accepted write and pop: `o_count` is unchanged and both pointers advance.
  - A pop never happens when empty.
- **FSM states:**
  - `S_IDLE`: if `!o_empty && i_tx_idle`, pop, latch the FIFO head into `o_tx_data`, and go to `S_TRIG`.
  - `S_TRIG`: `o_tx_trig` = 1 for exactly this cycle; go to `S_WAIT_BUSY`.
  - `S_WAIT_BUSY`: wait for `i_tx_idle` = 0, then go to `S_WAIT_IDLE`. The transmitter drops idle one cycle after the trigger; the FSM must never re-trigger off the stale idle level.
  - `S_WAIT_IDLE`: wait for `i_tx_idle` = 1, then go to `S_IDLE`.
- **`o_tx_data` hold:** `o_tx_data` holds its value from the pop until the next pop. The transmitter also latches it at the trigger.
- **Reset values:**
  - Reset (`rstn` low at an edge) returns the FSM to `S_IDLE` and clears both pointers and `o_count`.
  - Outputs: `o_empty` = 1, `o_full` = 0, `o_count` = 0, `o_overflow` = 0, `o_tx_trig` = 0, `o_tx_data` = 8'h00, `o_busy` = 0.
  - Reset has priority over writes in the same cycle.
- **Reset mid-operation:** FIFO contents are discarded. A byte already triggered is not recalled; the transmitter finishes it independently. The FSM waits in `S_IDLE` for `i_tx_idle` = 1 before the next trigger, so no trigger lands mid-frame.

## Timing
- **Status updates:** `o_count`, `o_full`, `o_empty` and `o_busy` update on the edge that accepts the write or performs the pop.
- **Write-to-trigger latency:** write accepted at edge N into an empty FIFO with `i_tx_idle` = 1:
  - pop at edge N+1;
  - `o_tx_trig` high between edges N+1 and N+2;
  - `o_tx_data` valid from edge N+1.
- **Back-to-back bytes:** the next trigger comes no earlier than 1 cycle after the FSM observes `i_tx_idle` rising.
- **Trigger spacing:** `o_tx_trig` is never high for two consecutive cycles. It is never asserted while `i_tx_idle` was low in the preceding cycle.
- **Stalled transmitter:** if `i_tx_idle` never falls, the FSM stays in `S_WAIT_BUSY` indefinitely. The FIFO still accepts writes until full.

## Test plan
- **Reset values:** hold `rstn` = 0 for 3 cycles -> all outputs at their reset values; `o_empty` = 1.
- **Single byte:** write 8'hA5 to an empty FIFO with an idle-model transmitter (drops idle 1 cycle after trigger, busy 12 cycles) -> trigger 1 cycle after the write, `o_tx_data` = 8'hA5, `o_count` back to 0, `o_busy` low after idle returns.
- **Burst:** write 8'h01..8'h10 on consecutive cycles with `DEPTH` = 16 -> `o_full` = 1 after the 16th write, no overflow, 16 triggers in order 01..10, each spaced at least 13 cycles apart.
- **Overflow:** with the transmitter stalled (idle held low), write 17 bytes -> `o_count` = 16, `o_overflow` = 1 and sticky. After release, the 16 stored bytes are sent and the 17th is absent.
- **Concurrent write and pop:** with `o_count` = 3, write in the same cycle the FSM pops -> `o_count` stays 3, and the read and write pointers wrap correctly across 0 over 40 bytes of streaming.
- **Reset mid-frame:** assert reset while in `S_WAIT_IDLE` with 5 bytes queued -> FIFO empty, no trigger until `i_tx_idle` returns high and a new write arrives.
